td4_ctrl: RTL and testbench

Run controller and program store for the TD4 4-bit core. Holds a 16x8 program memory that the host loads through a write port, serves instruction bytes to the core's `addr`/`data` fetch interface, and sequences the core through reset, free-run, single-step, pause and halt. Sits between the host/debug logic and the `td4` instance, driving its reset and clock-enable.

---
 rtl/td4_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_td4_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/td4_ctrl.sv
// td4_ctrl -- run controller and 16x8 program store for the TD4 4-bit core.
//
// Holds the program memory, which the host loads through a write port. It
// serves instruction bytes to the core fetch interface and drives the core
// reset and clock-enable. These sequence the core through reset, free-run,
// single-step, pause and halt.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   prog_we    in   program write strobe
//   prog_addr  in   [3:0] program write address
//   prog_data  in   [7:0] program write data
//   prog_ack   out  one-cycle pulse: write accepted (IDLE/HALT only)
//   prog_err   out  one-cycle pulse: write rejected (core active)
//   cmd_run    in   start/resume free-run
//   cmd_step   in   execute one instruction
//   cmd_stop   in   abort to IDLE (highest priority)
//   core_addr  in   [3:0] fetch address from core
//   core_data  out  [7:0] instruction byte at core_addr (combinational)
//   core_rst   out  active-high reset to core
//   core_ce    out  core clock enable, one instruction per enabled cycle
//   halted     out  high in HALT
//   busy       out  high in RESET, RUN, STEP
//   instr_cnt  out  [7:0] instructions executed since last restart, saturating
module td4_ctrl #(
    parameter int unsigned RESET_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       prog_we,
    input  logic [3:0] prog_addr,
    input  logic [7:0] prog_data,
    output logic       prog_ack,
    output logic       prog_err,
    input  logic       cmd_run,
    input  logic       cmd_step,
    input  logic       cmd_stop,
    input  logic [3:0] core_addr,
    output logic [7:0] core_data,
    output logic       core_rst,
    output logic       core_ce,
    output logic       halted,
    output logic       busy,
    output logic [7:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_STEP,
        S_PAUSE,
        S_HALT
    } state_t;

    // The counter is loaded with RESET_CYCLES-1 on entry to RESET. The last
    // RESET cycle is the one where it reads zero.
    localparam logic [3:0] RCNT_INIT = 4'(RESET_CYCLES - 1);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t      state_q, state_d;
    logic        tgt_step_q, tgt_step_d;   // target after RESET: 1 = STEP, 0 = RUN
    logic [3:0]  rcnt_q, rcnt_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        core_rst_q, core_rst_d;
    logic        core_ce_q, core_ce_d;
    logic        halted_q, halted_d;
    logic        busy_q, busy_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [7:0]  mem_q [16];

    logic        wr_ok;
    logic        self_jmp;

    assign core_data = mem_q[core_addr];

    // An unconditional JMP to its own address, executed this cycle, means the
    // program has finished.
    assign self_jmp = core_ce_q && (core_data == {4'hF, core_addr});

    assign wr_ok = prog_we && ((state_q == S_IDLE) || (state_q == S_HALT));

    always_comb begin
        state_d    = state_q;
        tgt_step_d = tgt_step_q;
        rcnt_d     = rcnt_q;

        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (cmd_stop) begin
                    state_d = S_IDLE;
                end else if (cmd_run) begin
                    state_d    = S_RESET;
                    tgt_step_d = 1'b0;
                    rcnt_d     = RCNT_INIT;
                end else if (cmd_step) begin
                    state_d    = S_RESET;
                    tgt_step_d = 1'b1;
                    rcnt_d     = RCNT_INIT;
                end
            end
            S_RESET: begin
                if (cmd_stop) begin
                    state_d = S_IDLE;
                end else if (rcnt_q == 4'd0) begin
                    state_d = tgt_step_q ? S_STEP : S_RUN;
                end else begin
                    rcnt_d = rcnt_q - 4'd1;
                end
            end
            S_RUN: begin
                if (cmd_stop) begin
                    state_d = S_IDLE;
                end else if (self_jmp) begin
                    state_d = S_HALT;
                end
            end
            S_STEP: begin
                if (cmd_stop) begin
                    state_d = S_IDLE;
                end else if (self_jmp) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (cmd_stop) begin
                    state_d = S_IDLE;
                end else if (cmd_run) begin
                    state_d = S_RUN;
                end else if (cmd_step) begin
                    state_d = S_STEP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state register.
    always_comb begin
        core_rst_d = (state_d == S_IDLE) || (state_d == S_RESET);
        core_ce_d  = (state_d == S_RUN) || (state_d == S_STEP);
        halted_d   = (state_d == S_HALT);
        busy_d     = (state_d == S_RESET) || (state_d == S_RUN) || (state_d == S_STEP);
        ack_d      = wr_ok;
        err_d      = prog_we && !wr_ok;

        cnt_d = cnt_q;
        if ((state_d == S_RESET) && (state_q != S_RESET)) begin
            cnt_d = 8'h00;
        end else if (core_ce_q) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            tgt_step_q <= 1'b0;
            rcnt_q     <= 4'd0;
            cnt_q      <= 8'h00;
            core_rst_q <= 1'b1;
            core_ce_q  <= 1'b0;
            halted_q   <= 1'b0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tgt_step_q <= tgt_step_d;
            rcnt_q     <= rcnt_d;
            cnt_q      <= cnt_d;
            core_rst_q <= core_rst_d;
            core_ce_q  <= core_ce_d;
            halted_q   <= halted_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (wr_ok) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    assign prog_ack  = ack_q;
    assign prog_err  = err_q;
    assign core_rst  = core_rst_q;
    assign core_ce   = core_ce_q;
    assign halted    = halted_q;
    assign busy      = busy_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_td4_ctrl.sv
module tb_td4_ctrl;

    logic       clk;
    logic       rst;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic       prog_ack;
    logic       prog_err;
    logic       cmd_run;
    logic       cmd_step;
    logic       cmd_stop;
    logic [3:0] core_addr;
    logic [7:0] core_data;
    logic       core_rst;
    logic       core_ce;
    logic       halted;
    logic       busy;
    logic [7:0] instr_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Write-response scoreboard: 2'b10 = ack expected, 2'b01 = err expected.
    logic [1:0]  wr_q [$];
    // Execution-trace scoreboard: {fetch address, instr_cnt during that cycle}.
    logic [11:0] tr_q [$];
    logic        trace_chk;

    // Simple core model: PC follows core_rst/core_ce, JMP when high nibble is F.
    logic [3:0] pc;
    logic       ovr;
    logic [3:0] rd_addr;

    assign core_addr = ovr ? rd_addr : pc;

    td4_ctrl #(.RESET_CYCLES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .prog_ack  (prog_ack),
        .prog_err  (prog_err),
        .cmd_run   (cmd_run),
        .cmd_step  (cmd_step),
        .cmd_stop  (cmd_stop),
        .core_addr (core_addr),
        .core_data (core_data),
        .core_rst  (core_rst),
        .core_ce   (core_ce),
        .halted    (halted),
        .busy      (busy),
        .instr_cnt (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= 4'd0;
        end else if (core_rst) begin
            pc <= 4'd0;
        end else if (core_ce) begin
            pc <= (core_data[7:4] == 4'hF) ? core_data[3:0] : pc + 4'd1;
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a response.
    always @(negedge clk) begin
        if (prog_ack || prog_err) begin
            if (wr_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL wr_resp_unexpected: got ack=%b err=%b expected none", prog_ack, prog_err);
            end else begin
                check("wr_resp", {14'd0, prog_ack, prog_err}, {14'd0, wr_q.pop_front()});
            end
        end
        if (core_ce && trace_chk) begin
            if (tr_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL trace_extra: got fetch addr %h expected no core_ce", core_addr);
            end else begin
                check("trace", {3'd0, core_rst, core_addr, instr_cnt}, {3'd0, 1'b0, tr_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prog_write(input logic [3:0] a, input logic [7:0] d, input logic [1:0] exp);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        wr_q.push_back(exp);
        tick();
        prog_we = 1'b0;
    endtask

    task automatic readback(input logic [3:0] a, input logic [7:0] exp);
        ovr     = 1'b1;
        rd_addr = a;
        #1;
        check($sformatf("mem[%0d]", a), {8'd0, core_data}, {8'd0, exp});
        ovr = 1'b0;
    endtask

    task automatic pulse(input int which);
        if (which == 0) cmd_run = 1'b1;
        if (which == 1) cmd_step = 1'b1;
        if (which == 2) cmd_stop = 1'b1;
        tick();
        cmd_run  = 1'b0;
        cmd_step = 1'b0;
        cmd_stop = 1'b0;
    endtask

    task automatic wait_halt(input int max);
        int n = 0;
        while (!halted && n < max) begin
            tick();
            n++;
        end
        check("halt_reached", {15'd0, halted}, 16'd1);
    endtask

    task automatic push_trace(input int first, input int last, input int cnt0);
        for (int i = first; i <= last; i++) begin
            tr_q.push_back({4'(i), 8'(cnt0 + i - first)});
        end
    endtask

    localparam logic [7:0] PROG [5] = '{8'h51, 8'h90, 8'h51, 8'h90, 8'hF4};

    initial begin
        rst = 1'b0; prog_we = 1'b0; prog_addr = 4'd0; prog_data = 8'd0;
        cmd_run = 1'b0; cmd_step = 1'b0; cmd_stop = 1'b0;
        ovr = 1'b0; rd_addr = 4'd0; trace_chk = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        tick();

        // Reset state
        check("rst_core_rst", {15'd0, core_rst}, 16'd1);
        check("rst_core_ce", {15'd0, core_ce}, 16'd0);
        check("rst_ack_err", {14'd0, prog_ack, prog_err}, 16'd0);
        check("rst_halted_busy", {14'd0, halted, busy}, 16'd0);
        check("rst_instr_cnt", {8'd0, instr_cnt}, 16'd0);
        for (int i = 0; i < 16; i++) readback(4'(i), 8'h00);

        // Program load in IDLE
        for (int i = 0; i < 5; i++) prog_write(4'(i), PROG[i], 2'b10);
        tick();
        for (int i = 0; i < 5; i++) readback(4'(i), PROG[i]);

        // Free run to self-JMP halt
        push_trace(0, 4, 0);
        pulse(0);
        check("run_reset1", {14'd0, core_rst, core_ce}, 16'b10);
        check("run_busy", {15'd0, busy}, 16'd1);
        tick();
        check("run_reset2", {14'd0, core_rst, core_ce}, 16'b10);
        tick();
        check("run_first_ce", {14'd0, core_rst, core_ce}, 16'b01);
        wait_halt(40);
        check("halt_cnt", {8'd0, instr_cnt}, 16'd5);
        check("halt_outs", {13'd0, core_rst, core_ce, busy}, 16'd0);
        check("halt_trace_done", 16'(tr_q.size()), 16'd0);

        // Stop, then single-step three times and resume
        pulse(2);
        check("stop_idle", {13'd0, core_rst, halted, busy}, 16'b100);
        push_trace(0, 4, 0);
        pulse(1);
        tick();
        tick();
        check("step1_ce", {13'd0, core_rst, core_ce, busy}, 16'b011);
        tick();
        check("pause1", {13'd0, core_rst, core_ce, busy}, 16'b000);
        repeat (3) tick();
        pulse(1);
        check("step2_ce", {14'd0, core_rst, core_ce}, 16'b01);
        tick();
        check("pause2", {15'd0, core_ce}, 16'd0);
        repeat (2) tick();
        pulse(1);
        tick();
        check("step3_cnt", {8'd0, instr_cnt}, 16'd3);
        check("pause3", {15'd0, core_ce}, 16'd0);
        pulse(0);
        check("resume_no_reset", {14'd0, core_rst, core_ce}, 16'b01);
        wait_halt(20);
        check("resume_cnt", {8'd0, instr_cnt}, 16'd5);

        // Looping program, write rejected while running, stop beats run
        prog_write(4'd4, 8'hF0, 2'b10);
        trace_chk = 1'b0;
        pulse(0);
        repeat (10) tick();
        check("loop_running", {14'd0, busy, core_ce}, 16'b11);
        prog_write(4'd2, 8'hAA, 2'b01);
        tick();
        cmd_stop = 1'b1;
        pulse(0);
        check("stop_over_run", {13'd0, core_rst, core_ce, busy}, 16'b100);
        tick();
        readback(4'd2, 8'h51);
        readback(4'd4, 8'hF0);
        trace_chk = 1'b1;

        // Asynchronous reset mid-run
        trace_chk = 1'b0;
        pulse(0);
        repeat (20) tick();
        #2 rst = 1'b0;
        #1;
        check("async_rst_outs", {11'd0, core_rst, core_ce, halted, busy, prog_ack}, 16'b10000);
        check("async_rst_cnt", {8'd0, instr_cnt}, 16'd0);
        tick();
        rst = 1'b1;
        tick();
        readback(4'd0, 8'h00);
        readback(4'd4, 8'h00);
        trace_chk = 1'b1;

        // Write accepted in the same cycle as run; restart uses the new byte
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = 8'hF0;
        wr_q.push_back(2'b10);
        push_trace(0, 0, 0);
        pulse(0);
        prog_we = 1'b0;
        wait_halt(20);
        check("f0_cnt", {8'd0, instr_cnt}, 16'd1);

        // Saturation of instr_cnt
        prog_write(4'd0, 8'h00, 2'b10);
        trace_chk = 1'b0;
        pulse(0);
        repeat (300) tick();
        check("sat_cnt", {8'd0, instr_cnt}, 16'h00FF);
        check("sat_running", {15'd0, core_ce}, 16'd1);
        pulse(2);
        check("sat_stop", {14'd0, core_rst, busy}, 16'b10);
        check("sat_cnt_kept", {8'd0, instr_cnt}, 16'h00FF);
        tick();

        check("wr_q_empty", 16'(wr_q.size()), 16'd0);
        check("tr_q_empty", 16'(tr_q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
